draw_rect: RTL

DRAW_RECT -- requirements
Module: draw_rect

---
 rtl/draw_rect.sv | 103 ++++++++++
 1 files changed

// File: rtl/draw_rect.sv
// Rectangle rasteriser: walks a latched rectangle in raster order, one pixel per cycle,
// emitting either every pixel (filled) or only the border pixels (outline).
module draw_rect #(
    parameter int XW = 8,
    parameter int YW = 8,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic [XW-1:0] x0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y0,
    input  logic [YW-1:0] y1,
    input  logic [CW-1:0] colour_in,
    output logic [XW-1:0] out_x,
    output logic [YW-1:0] out_y,
    output logic [CW-1:0] out_colour,
    output logic          plot,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t        state;
    logic [XW-1:0] left;
    logic [XW-1:0] right;
    logic [YW-1:0] top;
    logic [YW-1:0] bottom;
    logic          outline;
    logic          interior_row;

    assign interior_row = (out_y != top) && (out_y != bottom);

    // out_x/out_y are the pixel being presented; each DRAW cycle computes the next one.
    // Increments only happen below right/bottom, so full-range corners never wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            left       <= '0;
            right      <= '0;
            top        <= '0;
            bottom     <= '0;
            outline    <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
            out_colour <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    plot <= 1'b0;
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        left       <= (x0 < x1) ? x0 : x1;
                        right      <= (x0 < x1) ? x1 : x0;
                        top        <= (y0 < y1) ? y0 : y1;
                        bottom     <= (y0 < y1) ? y1 : y0;
                        out_x      <= (x0 < x1) ? x0 : x1;
                        out_y      <= (y0 < y1) ? y0 : y1;
                        outline    <= mode;
                        out_colour <= colour_in;
                        plot       <= 1'b1;
                        busy       <= 1'b1;
                        state      <= DRAW;
                    end
                end
                DRAW: begin
                    if (out_x == right && out_y == bottom) begin
                        plot  <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (out_x == right) begin
                        out_x <= left;
                        out_y <= out_y + YW'(1);
                    end else if (outline && interior_row && out_x == left) begin
                        // Interior outline rows jump straight from the left edge to the right edge.
                        out_x <= right;
                    end else begin
                        out_x <= out_x + XW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    plot  <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
